// File: rtl/dmem_port_arbiter_if.sv
// Request, response and DataMemory signal bundle for the two-requester data-memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters-plus-memory side.
interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0]         req_we;
  logic [1:0][DW-1:0] req_wdata;
  logic [1:0][1:0]    req_grain;
  logic [1:0]         req_sign;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [DW-1:0]      resp_rdata;
  logic               resp_err;
  logic [AW-1:0]      mem_address;
  logic               mem_we;
  logic               mem_re;
  logic [1:0]         mem_grain;
  logic               mem_sign;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_grain, req_sign,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_we, mem_re, mem_grain, mem_sign, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_grain, req_sign,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_we, mem_re, mem_grain, mem_sign, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter/sequencer for the single-ported DataMemory: one transaction at a time,
// one memory cycle per transaction, held response, misaligned/illegal-grain requests answered with an error.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester and latches its request
// ISSUE | drives DataMemory for one cycle (or flags an error) and captures the result
// RESP  | presents the held response to the owner until it is consumed
module dmem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                clock_i,
  input  logic                reset_i,
  dmem_port_arbiter_if.slave  bus_if
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      grain_q, grain_d;
  logic            sign_q, sign_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            grant;
  logic            legal;
  logic [1:0]      req_ready;
  logic [1:0]      resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic [AW-1:0]   mem_address;
  logic            mem_we;
  logic            mem_re;
  logic [1:0]      mem_grain;
  logic            mem_sign;
  logic [DW-1:0]   mem_wdata;

  // On contention the requester that did not win last time gets the port.
  always_comb begin
    if (&bus_if.req_valid) grant = ~last_grant_q;
    else                   grant = bus_if.req_valid[1];
  end

  always_comb begin
    case (grain_q)
      2'b00:   legal = (addr_q[1:0] == 2'b00);
      2'b01:   legal = 1'b1;
      2'b10:   legal = ~addr_q[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    grain_d      = grain_q;
    sign_d       = sign_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready    = 2'b00;
    resp_valid   = 2'b00;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    mem_address  = '0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_grain    = 2'b00;
    mem_sign     = 1'b0;
    mem_wdata    = '0;

    case (state_q)
      IDLE: begin
        if (|bus_if.req_valid) begin
          req_ready[grant] = 1'b1;
          owner_d          = grant;
          last_grant_d     = grant;
          addr_d           = bus_if.req_addr[grant];
          we_d             = bus_if.req_we[grant];
          wdata_d          = bus_if.req_wdata[grant];
          grain_d          = bus_if.req_grain[grant];
          sign_d           = bus_if.req_sign[grant];
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        if (legal) begin
          mem_address = addr_q;
          mem_grain   = grain_q;
          mem_sign    = sign_q;
          mem_wdata   = wdata_q;
          // A reset landing on this cycle must not let the store commit.
          mem_we      = we_q & ~reset_i;
          mem_re      = ~we_q;
          rdata_d     = we_q ? '0 : bus_if.mem_rdata;
          err_d       = 1'b0;
        end else begin
          rdata_d     = '0;
          err_d       = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid[owner_q] = 1'b1;
        resp_rdata          = rdata_q;
        resp_err            = err_q;
        if (bus_if.resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      grain_q      <= 2'b00;
      sign_q       <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      grain_q      <= grain_d;
      sign_q       <= sign_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus_if.req_ready   = req_ready;
  assign bus_if.resp_valid  = resp_valid;
  assign bus_if.resp_rdata  = resp_rdata;
  assign bus_if.resp_err    = resp_err;
  assign bus_if.mem_address = mem_address;
  assign bus_if.mem_we      = mem_we;
  assign bus_if.mem_re      = mem_re;
  assign bus_if.mem_grain   = mem_grain;
  assign bus_if.mem_sign    = mem_sign;
  assign bus_if.mem_wdata   = mem_wdata;

endmodule
